// File: rtl/dmem_bank_hs_if.sv
// dmem_bank_hs_if -- request/response handshake bundle of the data-memory bank.
//   req_valid    : request valid (master -> bank)
//   req_ready    : bank idle and able to accept (bank -> master)
//   req_we       : 1 = store, 0 = load
//   req_size     : 11 word, 10 half, 01 byte, 00 reserved
//   req_unsigned : zero-extend byte/half loads
//   req_addr     : byte address, AW bits
//   req_wdata    : store data, LSB-aligned
//   rsp_valid    : response valid (bank -> master)
//   rsp_ready    : master accepts the response
//   rsp_rdata    : extended load data, 0 for stores and faults
//   rsp_err      : access fault (or parity fault when enabled)
interface dmem_bank_hs_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank_hs.sv
// dmem_bank_hs -- parametrised byte-addressed 32-bit data-memory bank for the
// RV32I load/store unit, one access outstanding on a valid/ready interface.
//   CLK     : clock, rising edge
//   RST_N   : asynchronous active-low reset (array contents are not reset)
//   bus     : dmem_bank_hs_if.slave request/response channels
//   par_inj : (DMEM_PARITY_EN only) invert stored parity of bytes written
//             by the store accepted in this cycle
// Parameters: DEPTH words, AW address bits, RD_LAT response latency (1 or 2).
// Optional feature macro: DMEM_PARITY_EN -- adds one even-parity bit per
// byte, checked on the bytes a load touches.
// Misaligned, reserved-size and out-of-range accesses report rsp_err and
// never touch the array.
module dmem_bank_hs #(
    parameter int DEPTH  = 65536,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
`ifdef DMEM_PARITY_EN
    input  logic          par_inj,
`endif
    dmem_bank_hs_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
    localparam int LANE_W = 9;   // {parity, byte}
`else
    localparam int LANE_W = 8;
`endif

    typedef enum logic [1:0] {IDLE, PIPE, RESP} state_t;

    state_t      state_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        is_load_reg;
    logic        is_unsigned_reg;
    logic        acc_err_reg;
    logic [1:0]  size_reg;
    logic [1:0]  offset_reg;

    logic            accept;
    logic [AW-3:0]   word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic            out_of_range;
    logic            acc_err;
    logic [3:0]      lane_mask;
    logic [31:0]     wr_data;
    logic            wr_en;
    logic            rd_en;
    logic [31:0]     rd_word;

    assign accept       = bus.req_valid && req_ready_reg;
    assign word_idx     = bus.req_addr[AW-1:2];
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign out_of_range = (64'(word_idx) >= 64'(DEPTH));

    // Decode size/alignment into a byte-lane mask and lane-replicated store
    // data so every lane simply writes its own slice.
    always_comb begin
        acc_err   = out_of_range;
        lane_mask = 4'b0000;
        wr_data   = bus.req_wdata;
        case (bus.req_size)
            2'b11: begin
                lane_mask = 4'b1111;
                if (bus.req_addr[1:0] != 2'b00) acc_err = 1'b1;
            end
            2'b10: begin
                lane_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{bus.req_wdata[15:0]}};
                if (bus.req_addr[0]) acc_err = 1'b1;
            end
            2'b01: begin
                lane_mask = 4'b0001 << bus.req_addr[1:0];
                wr_data   = {4{bus.req_wdata[7:0]}};
            end
            default: acc_err = 1'b1;
        endcase
    end

    assign wr_en = accept && bus.req_we && !acc_err;
    assign rd_en = accept && !bus.req_we && !acc_err;

`ifdef DMEM_PARITY_EN
    logic [3:0] lane_mask_reg;
    logic [3:0] rd_par;
`endif

    // One narrow RAM per byte lane gives per-byte write enables; the read
    // register (and optional second stage) only loads on an accepted load,
    // so the response holds for as long as the consumer stalls.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [LANE_W-1:0] mem_lane [DEPTH];
        logic [LANE_W-1:0] wr_lane;
        logic [LANE_W-1:0] rd_s1_reg;
        logic [LANE_W-1:0] rd_out;

`ifdef DMEM_PARITY_EN
        assign wr_lane = {(^wr_data[8*gi +: 8]) ^ par_inj, wr_data[8*gi +: 8]};
        assign rd_par[gi] = rd_out[8];
`else
        assign wr_lane = wr_data[8*gi +: 8];
`endif

        always_ff @(posedge CLK) begin
            if (wr_en && lane_mask[gi]) mem_lane[mem_idx] <= wr_lane;
            if (rd_en) rd_s1_reg <= mem_lane[mem_idx];
        end

        if (RD_LAT == 2) begin : g_s2
            logic [LANE_W-1:0] rd_s2_reg;
            always_ff @(posedge CLK) begin
                if (state_reg == PIPE) rd_s2_reg <= rd_s1_reg;
            end
            assign rd_out = rd_s2_reg;
        end else begin : g_s1
            assign rd_out = rd_s1_reg;
        end

        assign rd_word[8*gi +: 8] = rd_out[7:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            is_load_reg     <= 1'b0;
            is_unsigned_reg <= 1'b0;
            acc_err_reg     <= 1'b0;
            size_reg        <= 2'b00;
            offset_reg      <= 2'b00;
`ifdef DMEM_PARITY_EN
            lane_mask_reg   <= 4'b0000;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        is_load_reg     <= !bus.req_we;
                        is_unsigned_reg <= bus.req_unsigned;
                        acc_err_reg     <= acc_err;
                        size_reg        <= bus.req_size;
                        offset_reg      <= bus.req_addr[1:0];
`ifdef DMEM_PARITY_EN
                        lane_mask_reg   <= lane_mask;
`endif
                        req_ready_reg   <= 1'b0;
                        if (RD_LAT == 2) begin
                            state_reg <= PIPE;
                        end else begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                        end
                    end
                end
                PIPE: begin
                    state_reg     <= RESP;
                    rsp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Lane select and extension work on the held read word.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;
    logic        load_ok;

    always_comb begin
        sel_byte = rd_word[{offset_reg, 3'b000} +: 8];
        sel_half = offset_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_reg)
            2'b01:   ext_data = is_unsigned_reg ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'b10:   ext_data = is_unsigned_reg ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: ext_data = rd_word;
        endcase
    end

    assign load_ok       = is_load_reg && !acc_err_reg;
    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = (rsp_valid_reg && load_ok) ? ext_data : 32'h0;

`ifdef DMEM_PARITY_EN
    // Only the lanes this load touched can raise a parity fault.
    logic [3:0] par_calc;
    logic       par_err;
    for (genvar gi = 0; gi < 4; gi++) begin : g_par
        assign par_calc[gi] = ^rd_word[8*gi +: 8];
    end
    assign par_err     = |(lane_mask_reg & (par_calc ^ rd_par));
    assign bus.rsp_err = rsp_valid_reg && (acc_err_reg || (load_ok && par_err));
`else
    assign bus.rsp_err = rsp_valid_reg && acc_err_reg;
`endif
endmodule

// File: tb/tb_dmem_bank_hs.sv
// Testbench for dmem_bank_hs: directed vector table, stall/reset sequence,
// then randomized traffic checked against a byte-array reference model.
module tb_dmem_bank_hs;
    localparam int DEPTH  = 256;
    localparam int AW     = 32;
    localparam int RD_LAT = 1;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    dmem_bank_hs_if #(.AW(AW)) bus ();
`ifdef DMEM_PARITY_EN
    logic par_inj;
`endif

    dmem_bank_hs #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
`ifdef DMEM_PARITY_EN
        .par_inj(par_inj),
`endif
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    // Reference model: plain byte array, rules applied arithmetically.
    logic [7:0]  mdl [DEPTH*4];
    logic [31:0] m_rdata;
    logic        m_err;

    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        int nb;
        logic [31:0] v;
        nb    = (size == 2'b11) ? 4 : (size == 2'b10) ? 2 : (size == 2'b01) ? 1 : 0;
        rdata = 32'h0;
        if (nb == 0) begin
            err = 1'b1;
            return;
        end
        err = ((addr % nb) != 0) || ({32'h0, addr} >= 64'(DEPTH) * 64'd4);
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mdl[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[addr + i];
            if (!uns && nb < 4 && v[8*nb-1]) begin
                for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
            end
            rdata = v;
        end
    endfunction

    function automatic void add_vec(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] exp_rdata, input logic exp_err);
        vecs.push_back('{we, size, uns, addr, wdata, exp_rdata, exp_err});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Present a request and wait for it to be accepted; afterwards keep
    // req_valid high with an unrelated store that must be ignored.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
        int n = 0;
        @(negedge CLK);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.rsp_ready    = 1'b0;
        while (!bus.req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: req_ready got 0, expected 1");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b11;
        bus.req_addr  = 32'($urandom_range(0, 31)) << 2;
        bus.req_wdata = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus.rsp_valid && lat < 50);
        if (!bus.rsp_valid) begin
            n_checks++;
            $display("FAIL rsp_timeout: rsp_valid got 0, expected 1");
        end
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic xact(input string name, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        input logic [31:0] exp_rdata, input logic exp_err);
        bit ok;
        int lat;
        issue(we, size, uns, addr, wdata, ok);
        if (!ok) return;
        wait_rsp(lat);
        $display("xact %s we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 name, we, size, uns, addr, wdata, bus.rsp_rdata, bus.rsp_err, lat);
        check({name, "_lat"},   32'(lat), 32'(RD_LAT));
        check({name, "_rdata"}, bus.rsp_rdata, exp_rdata);
        check({name, "_err"},   32'(bus.rsp_err), 32'(exp_err));
        for (int k = 0; k < stall; k++) begin
            @(negedge CLK);
            check({name, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({name, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
            check({name, "_hold_err"},   32'(bus.rsp_err), 32'(exp_err));
            check({name, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        release_rsp();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        logic [31:0] addr, wdata;
        logic [1:0]  size;
        logic        we, uns;
        int          r;

        // Spec-derived vectors: {we, size, uns, addr, wdata, exp_rdata, exp_err}
        add_vec(1, 2'b11, 0, 32'h010, 32'h12345678, 32'h00000000, 0);
        add_vec(0, 2'b11, 0, 32'h010, 32'h0,        32'h12345678, 0);
        add_vec(1, 2'b01, 0, 32'h013, 32'h123456AB, 32'h00000000, 0);
        add_vec(0, 2'b01, 0, 32'h013, 32'h0,        32'hFFFFFFAB, 0);
        add_vec(0, 2'b01, 1, 32'h013, 32'h0,        32'h000000AB, 0);
        add_vec(0, 2'b11, 0, 32'h010, 32'h0,        32'hAB345678, 0);
        add_vec(1, 2'b10, 0, 32'h012, 32'hDEAD8001, 32'h00000000, 0);
        add_vec(0, 2'b10, 0, 32'h012, 32'h0,        32'hFFFF8001, 0);
        add_vec(0, 2'b10, 1, 32'h012, 32'h0,        32'h00008001, 0);
        add_vec(0, 2'b10, 0, 32'h010, 32'h0,        32'h00005678, 0);
        add_vec(1, 2'b11, 0, 32'h000, 32'hCAFEF00D, 32'h00000000, 0);
        add_vec(0, 2'b11, 0, 32'h011, 32'h0,        32'h00000000, 1);
        add_vec(1, 2'b10, 0, 32'h013, 32'h0000FFFF, 32'h00000000, 1);
        add_vec(1, 2'b00, 0, 32'h010, 32'h77777777, 32'h00000000, 1);
        add_vec(0, 2'b00, 0, 32'h010, 32'h0,        32'h00000000, 1);
        add_vec(1, 2'b11, 0, 32'h400, 32'h11111111, 32'h00000000, 1);
        add_vec(0, 2'b11, 0, 32'h400, 32'h0,        32'h00000000, 1);
        add_vec(0, 2'b11, 0, 32'h010, 32'h0,        32'h80015678, 0);
        add_vec(0, 2'b11, 0, 32'h000, 32'h0,        32'hCAFEF00D, 0);
        add_vec(0, 2'b01, 0, 32'h012, 32'h0,        32'h00000001, 0);
        add_vec(0, 2'b01, 0, 32'h011, 32'h0,        32'h00000056, 0);
        add_vec(0, 2'b01, 0, 32'h013, 32'h0,        32'hFFFFFF80, 0);
        add_vec(0, 2'b01, 1, 32'h013, 32'h0,        32'h00000080, 0);
        add_vec(0, 2'b10, 1, 32'h010, 32'h0,        32'h00005678, 0);
        add_vec(0, 2'b10, 0, 32'h000, 32'h0,        32'hFFFFF00D, 0);
        add_vec(1, 2'b11, 0, 32'h3FC, 32'hA5A5A5A5, 32'h00000000, 0);
        add_vec(0, 2'b11, 0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 0);

        // Reset state
        RST_N            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
`ifdef DMEM_PARITY_EN
        par_inj          = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Table-driven vectors; the model tracks every access.
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, m_rdata, m_err);
            xact($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                 vecs[i].wdata, i % 3, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Five-cycle consumer stall on a load
        model(0, 2'b11, 0, 32'h10, 32'h0, m_rdata, m_err);
        xact("stall_lw", 0, 2'b11, 0, 32'h10, 32'h0, 5, 32'h80015678, 0);

        // Reset while a store response is stalled: response dropped, store kept
        model(1, 2'b11, 0, 32'h14, 32'h5A5AA5A5, m_rdata, m_err);
        issue(1, 2'b11, 0, 32'h14, 32'h5A5AA5A5, ok);
        if (ok) begin
            wait_rsp(lat);
            repeat (2) @(negedge CLK);
            check("midrst_pre_valid", 32'(bus.rsp_valid), 32'd1);
            RST_N = 1'b0;
            #1;
            $display("xact midrst reset asserted during stalled store: rsp_valid=%0d req_ready=%0d",
                     bus.rsp_valid, bus.req_ready);
            check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
            check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
            bus.req_valid = 1'b0;
            repeat (2) @(negedge CLK);
            RST_N = 1'b1;
            @(negedge CLK);
            check("midrst_ready_back", 32'(bus.req_ready), 32'd1);
        end
        xact("after_rst_lw14", 0, 2'b11, 0, 32'h14, 32'h0, 0, 32'h5A5AA5A5, 0);
        xact("after_rst_lw10", 0, 2'b11, 0, 32'h10, 32'h0, 0, 32'h80015678, 0);

        // Preload the random-traffic window so every byte is known
        for (int w = 0; w < 32; w++) begin
            wdata = $urandom;
            model(1, 2'b11, 0, 32'(w * 4), wdata, m_rdata, m_err);
            xact("preload", 1, 2'b11, 0, 32'(w * 4), wdata, 0, m_rdata, m_err);
        end

        // Randomized traffic against the model
        for (int t = 0; t < 200; t++) begin
            r     = $urandom_range(0, 99);
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            size  = (r < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            if (r >= 6 && r < 12) begin
                addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1023));
            end else if (r >= 12 && r < 15) begin
                addr = $urandom | 32'h8000_0000;
            end else begin
                addr = 32'($urandom_range(0, 127));
                if ($urandom_range(0, 3) != 0) begin
                    if (size == 2'b11) addr = addr & ~32'h3;
                    else if (size == 2'b10) addr = addr & ~32'h1;
                end
            end
            model(we, size, uns, addr, wdata, m_rdata, m_err);
            xact("rand", we, size, uns, addr, wdata, $urandom_range(0, 2), m_rdata, m_err);
        end

`ifdef DMEM_PARITY_EN
        // Corrupted parity on one byte faults only loads that touch it
        par_inj = 1'b1;
        model(1, 2'b01, 0, 32'h20, 32'h55, m_rdata, m_err);
        xact("par_sb20", 1, 2'b01, 0, 32'h20, 32'h55, 0, 32'h0, 0);
        par_inj = 1'b0;
        xact("par_lb20", 0, 2'b01, 0, 32'h20, 32'h0, 0, 32'h55, 1);
        model(0, 2'b01, 0, 32'h21, 32'h0, m_rdata, m_err);
        xact("par_lb21", 0, 2'b01, 0, 32'h21, 32'h0, 0, m_rdata, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
